// File: rtl/top_control_cpu.sv
// 16-bit accumulator CPU: IRAM/DRAM, PC/AR/IR/AC, ALU and multi-cycle control FSM; 3-5 clocks per instruction, no backpressure.
// Define TOP_CONTROL_DEBUG_EN to drive control_out, state, data_in_pc and the ALU taps; otherwise they read as zero.
module top_control_cpu (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        start_2,
    input  logic [8:0]  addr_ext,
    input  logic        iram_write_ext,
    input  logic [15:0] Data_in_ins,
    output logic [15:0] iram_in,
    output logic [15:0] dram_in,
    output logic [15:0] dram_out,
    output logic [15:0] pc_out,
    output logic [15:0] ar_out,
    output logic [1:0]  read_en,
    output logic        write_en,
    output logic [19:0] control_out,
    output logic [5:0]  state,
    output logic [15:0] data_in_pc,
    output logic [15:0] alu_in_1,
    output logic [15:0] alu_in_2,
    output logic [15:0] alu_out
);

    typedef enum logic [5:0] {
        S_IDLE   = 6'd0,
        S_FETCH1 = 6'd1,
        S_FETCH2 = 6'd2,
        S_DECODE = 6'd3,
        S_LDAC1  = 6'd4,
        S_LDAC2  = 6'd5,
        S_ADD1   = 6'd6,
        S_ADD2   = 6'd7,
        S_SUB1   = 6'd8,
        S_SUB2   = 6'd9,
        S_STAC1  = 6'd10,
        S_STAC2  = 6'd11,
        S_INAC   = 6'd12,
        S_JUMP   = 6'd13,
        S_JMPZ   = 6'd14,
        S_HALT   = 6'd63
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ar_q, ar_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ac_q, ac_d;
    logic        z_q, z_d;

    // DRAM cells hold (data ^ address) so the all-zero power-up image reads back as DRAM[i]=i.
    logic [15:0] iram_q [0:511] = '{default: 16'h0000};
    logic [15:0] dram_q [0:511] = '{default: 16'h0000};

    logic        ar_ld_pc, ar_ld_ir, ir_ld, pc_inc, pc_ld, ac_ld;
    logic        dram_we, iram_re, dram_re, halt;
    logic [2:0]  alu_op;
    logic        run;
    logic [15:0] iram_rd, dram_rd;
    logic [15:0] alu_b, alu_res, pc_next;

    assign run     = start & ~start_2;
    assign iram_rd = iram_q[ar_q[8:0]];
    assign dram_rd = dram_q[ar_q[8:0]] ^ {7'b0, ar_q[8:0]};

    always_comb begin
        ar_ld_pc = 1'b0;
        ar_ld_ir = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        ac_ld    = 1'b0;
        dram_we  = 1'b0;
        iram_re  = 1'b0;
        dram_re  = 1'b0;
        halt     = 1'b0;
        alu_op   = 3'd0;
        state_d  = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH1;
            S_FETCH1: begin
                ar_ld_pc = 1'b1;
                state_d  = run ? S_FETCH2 : S_IDLE;
            end
            S_FETCH2: begin
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                iram_re = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[15:10])
                    6'd1:    state_d = S_LDAC1;
                    6'd2:    state_d = S_ADD1;
                    6'd3:    state_d = S_STAC1;
                    6'd4:    state_d = S_SUB1;
                    6'd5:    state_d = S_INAC;
                    6'd6:    state_d = S_JUMP;
                    6'd7:    state_d = S_JMPZ;
                    6'd63:   state_d = S_HALT;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_LDAC1: begin ar_ld_ir = 1'b1; state_d = S_LDAC2; end
            S_ADD1:  begin ar_ld_ir = 1'b1; state_d = S_ADD2;  end
            S_SUB1:  begin ar_ld_ir = 1'b1; state_d = S_SUB2;  end
            S_STAC1: begin ar_ld_ir = 1'b1; state_d = S_STAC2; end
            S_LDAC2: begin
                ac_ld   = 1'b1;
                dram_re = 1'b1;
                alu_op  = 3'd0;
                state_d = S_FETCH1;
            end
            S_ADD2: begin
                ac_ld   = 1'b1;
                dram_re = 1'b1;
                alu_op  = 3'd1;
                state_d = S_FETCH1;
            end
            S_SUB2: begin
                ac_ld   = 1'b1;
                dram_re = 1'b1;
                alu_op  = 3'd2;
                state_d = S_FETCH1;
            end
            S_STAC2: begin dram_we = 1'b1; state_d = S_FETCH1; end
            S_INAC: begin
                ac_ld   = 1'b1;
                alu_op  = 3'd3;
                state_d = S_FETCH1;
            end
            S_JUMP: begin pc_ld = 1'b1; state_d = S_FETCH1; end
            S_JMPZ: begin pc_ld = z_q;  state_d = S_FETCH1; end
            S_HALT: begin
                halt = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset wins even mid-instruction: no strobes, so a pending STAC write never lands.
        if (!reset_n) begin
            ar_ld_pc = 1'b0;
            ar_ld_ir = 1'b0;
            ir_ld    = 1'b0;
            pc_inc   = 1'b0;
            pc_ld    = 1'b0;
            ac_ld    = 1'b0;
            dram_we  = 1'b0;
            iram_re  = 1'b0;
            dram_re  = 1'b0;
            halt     = 1'b0;
            alu_op   = 3'd0;
            state_d  = S_IDLE;
        end
    end

    always_comb begin
        alu_b = (alu_op == 3'd3) ? 16'd1 : dram_rd;
        case (alu_op)
            3'd1:    alu_res = ac_q + alu_b;
            3'd2:    alu_res = ac_q - alu_b;
            3'd3:    alu_res = ac_q + alu_b;
            default: alu_res = alu_b;
        endcase
        pc_next = pc_ld ? {6'b0, ir_q[9:0]} : {7'b0, pc_q[8:0] + 9'd1};

        pc_d = pc_q;
        ar_d = ar_q;
        ir_d = ir_q;
        ac_d = ac_q;
        z_d  = z_q;
        if (pc_inc || pc_ld) pc_d = pc_next;
        if (ar_ld_pc)        ar_d = pc_q;
        else if (ar_ld_ir)   ar_d = {6'b0, ir_q[9:0]};
        if (ir_ld)           ir_d = iram_rd;
        if (ac_ld) begin
            ac_d = alu_res;
            z_d  = (alu_res == 16'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= 16'd0;
            ar_q    <= 16'd0;
            ir_q    <= 16'd0;
            ac_q    <= 16'd0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ar_q    <= ar_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            z_q     <= z_d;
        end
    end

    // Memories are deliberately outside reset so a reset pulse keeps the loaded program and data.
    always_ff @(posedge clock) begin
        if (reset_n && start_2 && iram_write_ext) iram_q[addr_ext] <= Data_in_ins;
        if (dram_we) dram_q[ar_q[8:0]] <= ac_q ^ {7'b0, ar_q[8:0]};
    end

    assign iram_in  = iram_rd;
    assign dram_in  = ac_q;
    assign dram_out = dram_rd;
    assign pc_out   = pc_q;
    assign ar_out   = ar_q;
    assign read_en  = {dram_re, iram_re};
    assign write_en = dram_we;

`ifdef TOP_CONTROL_DEBUG_EN
    assign control_out = {7'b0, halt, alu_op, dram_re, iram_re, dram_we, ac_ld,
                          pc_ld, pc_inc, ir_ld, ar_ld_ir, ar_ld_pc};
    assign state       = state_q;
    assign data_in_pc  = pc_next;
    assign alu_in_1    = ac_q;
    assign alu_in_2    = alu_b;
    assign alu_out     = alu_res;
`else
    logic dbg_unused;
    assign dbg_unused  = halt;
    assign control_out = 20'd0;
    assign state       = 6'd0;
    assign data_in_pc  = 16'd0;
    assign alu_in_1    = 16'd0;
    assign alu_in_2    = 16'd0;
    assign alu_out     = 16'd0;
`endif

endmodule

// File: tb/tb_top_control_cpu.sv
// Scoreboard bench for top_control_cpu: directed programs push expected AC loads and DRAM writes; a monitor pops and compares.
module tb_top_control_cpu;

    logic        clock = 1'b0;
    logic        reset_n, start, start_2, iram_write_ext;
    logic [8:0]  addr_ext;
    logic [15:0] Data_in_ins;
    logic [15:0] iram_in, dram_in, dram_out, pc_out, ar_out;
    logic [1:0]  read_en;
    logic        write_en;
    logic [19:0] control_out;
    logic [5:0]  state;
    logic [15:0] data_in_pc, alu_in_1, alu_in_2, alu_out;

    always #5 clock = ~clock;

    top_control_cpu dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_2(start_2),
        .addr_ext(addr_ext), .iram_write_ext(iram_write_ext), .Data_in_ins(Data_in_ins),
        .iram_in(iram_in), .dram_in(dram_in), .dram_out(dram_out),
        .pc_out(pc_out), .ar_out(ar_out), .read_en(read_en), .write_en(write_en),
        .control_out(control_out), .state(state), .data_in_pc(data_in_pc),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out)
    );

    typedef struct packed {
        logic        is_wr;
        logic [8:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] tb_iram [0:511];
    logic        prev_dram_re = 1'b0;
    logic        prev_we = 1'b0;

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ld(input logic [15:0] v);
        sb_q.push_back('{is_wr: 1'b0, addr: 9'd0, data: v});
    endtask

    task automatic expect_wr(input logic [8:0] a, input logic [15:0] v);
        sb_q.push_back('{is_wr: 1'b1, addr: a, data: v});
    endtask

    task automatic pop_cmp(input logic is_wr);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s with data %h, none expected",
                     is_wr ? "write" : "load", dram_in);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", {19'd0, is_wr}, {19'd0, e.is_wr});
            if (is_wr) chk("wr_addr", {11'd0, ar_out[8:0]}, {11'd0, e.addr});
            chk(is_wr ? "wr_data" : "ac_load", {4'd0, dram_in}, {4'd0, e.data});
        end
    endtask

    // Monitor: fetch words against the IRAM model, AC one clock after a DRAM read, and each write strobe.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (read_en[0]) chk("fetch_word", {4'd0, iram_in}, {4'd0, tb_iram[ar_out[8:0]]});
            if (prev_dram_re) pop_cmp(1'b0);
            if (write_en) begin
                if (prev_we) chk("we_one_clock", 20'd1, 20'd0);
                pop_cmp(1'b1);
            end
        end
        prev_dram_re = (reset_n === 1'b1) && read_en[1];
        prev_we      = (reset_n === 1'b1) && write_en;
    end

    task automatic do_reset(input bit do_check);
        @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b0;
        start_2 = 1'b0;
        repeat (2) @(negedge clock);
        if (do_check) begin
            chk("rst_pc", {4'd0, pc_out}, 20'd0);
            chk("rst_ar", {4'd0, ar_out}, 20'd0);
            chk("rst_ac", {4'd0, dram_in}, 20'd0);
            chk("rst_read_en", {18'd0, read_en}, 20'd0);
            chk("rst_write_en", {19'd0, write_en}, 20'd0);
            chk("rst_state", {14'd0, state}, 20'd0);
            chk("rst_ctrl", control_out, 20'd0);
        end
        reset_n = 1'b1;
    endtask

    task automatic iram_wr(input logic [8:0] a, input logic [15:0] d);
        @(negedge clock);
        addr_ext       = a;
        Data_in_ins    = d;
        iram_write_ext = 1'b1;
        @(negedge clock);
        iram_write_ext = 1'b0;
        if (start_2) tb_iram[a] = d;
    endtask

    task automatic run_cycles(input int n);
        @(negedge clock);
        start = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic sb_drained(input string name);
        chk(name, sb_q.size(), 20'd0);
        sb_q.delete();
    endtask

    // Halted checks: PC/AR where the HALT was fetched, then start=0 parks the FSM in IDLE.
    task automatic check_halt(input string name, input logic [15:0] pc_exp);
        chk({name, "_pc"}, {4'd0, pc_out}, {4'd0, pc_exp});
        chk({name, "_ar"}, {4'd0, ar_out}, {4'd0, pc_exp - 16'd1});
`ifdef TOP_CONTROL_DEBUG_EN
        chk({name, "_state_halt"}, {14'd0, state}, 20'd63);
        chk({name, "_ctrl_halt"}, control_out, 20'h01000);
`else
        chk({name, "_state_tied"}, {14'd0, state}, 20'd0);
        chk({name, "_ctrl_tied"}, control_out, 20'd0);
`endif
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk({name, "_idle_state"}, {14'd0, state}, 20'd0);
        chk({name, "_idle_pc"}, {4'd0, pc_out}, {4'd0, pc_exp});
        chk({name, "_idle_read_en"}, {18'd0, read_en}, 20'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] pc_snap;
        reset_n = 1'b0; start = 1'b0; start_2 = 1'b0;
        addr_ext = 9'd0; iram_write_ext = 1'b0; Data_in_ins = 16'd0;
        for (int i = 0; i < 512; i++) tb_iram[i] = 16'h0000;

        do_reset(1'b1);

        // Load mode, then a write attempt with start_2=0 that must be ignored.
        start_2 = 1'b1;
        iram_wr(9'd1, 16'h0000);
        iram_wr(9'd2, 16'h0401);
        iram_wr(9'd3, 16'h0802);
        iram_wr(9'd4, 16'h1400);
        iram_wr(9'd5, 16'h0C03);
        start_2 = 1'b0;
        iram_wr(9'd3, 16'hFFFF);

        expect_ld(16'd1);
        expect_ld(16'd3);
        expect_wr(9'd3, 16'd4);
        run_cycles(40);
        start = 1'b0;
        repeat (10) @(negedge clock);
        sb_drained("prog1_drained");
        pc_snap = pc_out;
        repeat (10) @(negedge clock);
        chk("stop_pc_hold", {4'd0, pc_out}, {4'd0, pc_snap});
        chk("stop_read_en", {18'd0, read_en}, 20'd0);

        // Z set by LDAC of DRAM[0] -> JMPZ taken to 10.
        do_reset(1'b0);
        start_2 = 1'b1;
        iram_wr(9'd0, 16'h0405);
        iram_wr(9'd1, 16'h0400);
        iram_wr(9'd2, 16'h1C0A);
        iram_wr(9'd10, 16'hFC00);
        start_2 = 1'b0;
        expect_ld(16'd5);
        expect_ld(16'd0);
        run_cycles(40);
        sb_drained("jmpz_taken_drained");
        check_halt("jmpz_taken", 16'd11);

        // Z cleared -> JMPZ falls through.
        do_reset(1'b0);
        start_2 = 1'b1;
        iram_wr(9'd0, 16'h0400);
        iram_wr(9'd1, 16'h0405);
        iram_wr(9'd2, 16'h1C0A);
        iram_wr(9'd3, 16'hFC00);
        start_2 = 1'b0;
        expect_ld(16'd0);
        expect_ld(16'd5);
        run_cycles(40);
        sb_drained("jmpz_not_drained");
        check_halt("jmpz_not", 16'd4);

        // SUB with borrow, JUMP, STAC/LDAC round trip, undefined opcode as NOP.
        do_reset(1'b0);
        start_2 = 1'b1;
        iram_wr(9'd0, 16'h0407);
        iram_wr(9'd1, 16'h1009);
        iram_wr(9'd2, 16'h1814);
        iram_wr(9'd20, 16'h0C1E);
        iram_wr(9'd21, 16'h2000);
        iram_wr(9'd22, 16'h041E);
        iram_wr(9'd23, 16'hFC00);
        start_2 = 1'b0;
        expect_ld(16'd7);
        expect_ld(16'hFFFE);
        expect_wr(9'd30, 16'hFFFE);
        expect_ld(16'hFFFE);
        run_cycles(60);
        sb_drained("sub_jump_drained");
        check_halt("sub_jump", 16'd24);

        // HALT at IRAM[1] after a NOP.
        do_reset(1'b0);
        start_2 = 1'b1;
        iram_wr(9'd0, 16'h0000);
        iram_wr(9'd1, 16'hFC00);
        start_2 = 1'b0;
        run_cycles(20);
        check_halt("halt", 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_control_cpu.md
# top_control_cpu

Top-level datapath and control unit of the simple 16-bit accumulator processor. It contains a 512x16 instruction RAM (IRAM), a 512x16 data RAM (DRAM), the PC, AR, IR and AC registers, an ALU and a multi-cycle control FSM. The IRAM is loaded through an external write port while the processor is parked, then the processor runs the program when `start` is asserted. Internal control and datapath nodes are exported for board-level debug.

## Interface
- No parameters.
- clock  in  1  rising-edge system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  run enable; the processor executes only while start=1 and start_2=0
- start_2  in  1  load mode; enables external IRAM writes
- addr_ext  in  9  external IRAM write address
- iram_write_ext  in  1  external IRAM write strobe, sampled each clock
- Data_in_ins  in  16  external IRAM write data
- iram_in  out  16  IRAM read data at address AR[8:0], i.e. the instruction word
- dram_in  out  16  DRAM write data, always equal to AC
- dram_out  out  16  DRAM read data at address AR[8:0]
- pc_out / ar_out  out  16  PC / AR register values
- read_en  out  2  bit0 IRAM read (FETCH2), bit1 DRAM read (LDAC2/ADD2/SUB2)
- write_en  out  1  DRAM write (STAC2)
- control_out  out  20  decoded control word
- state  out  6  FSM state code
- data_in_pc  out  16  next-PC value (PC+1, or IR[9:0] zero-extended on a jump)
- alu_in_1 / alu_in_2 / alu_out  out  16  ALU A input (AC) / B input (dram_out, or 1 for INAC) / ALU result

## Operation
- Instruction format: opcode in IR[15:10], operand address in IR[9:0]. Only IR[8:0] addresses memory.
- Opcodes:
  - 0 NOP
  - 1 LDAC: AC=M
  - 2 ADD: AC=AC+M
  - 3 STAC: M=AC
  - 4 SUB: AC=AC-M
  - 5 INAC: AC=AC+1
  - 6 JUMP: PC=opr
  - 7 JMPZ: PC=opr if Z
  - 63 HALT
  - Every other opcode executes as NOP.
- Arithmetic is 16-bit modulo 2^16. Z is set to (new AC==0) on every AC load.
- Memory: both RAMs use synchronous writes and asynchronous reads. Power-up contents are IRAM[i]=0 and DRAM[i]=i. Reset does not change memory contents.
- External IRAM write: IRAM[addr_ext] <= Data_in_ins on any clock edge where start_2=1 and iram_write_ext=1.
- FSM state codes:
  - IDLE=0, FETCH1=1, FETCH2=2, DECODE=3
  - LDAC1=4, LDAC2=5, ADD1=6, ADD2=7, SUB1=8, SUB2=9, STAC1=10, STAC2=11
  - INAC=12, JUMP=13, JMPZ=14, HALT=63
- FSM transitions and actions:
  - IDLE goes to FETCH1 when start=1 and start_2=0.
  - FETCH1: AR<=PC. If the run condition is false, go to IDLE instead.
  - FETCH2: IR<=IRAM[AR], PC<=PC+1.
  - DECODE: branch on the opcode. NOP and undefined opcodes return to FETCH1.
  - xx1 states: AR<=IR[9:0]. xx2 states perform the memory/ALU operation, then go to FETCH1.
  - INAC, JUMP and JMPZ go to FETCH1.
  - HALT holds until start=0, then goes to IDLE.
- control_out bits:
  - 0 ar_ld_pc, 1 ar_ld_ir, 2 ir_ld, 3 pc_inc, 4 pc_ld, 5 ac_ld, 6 dram_we, 7 iram_re, 8 dram_re
  - [11:9] alu_op: 0 pass B, 1 add, 2 sub, 3 inc
  - 12 halt
  - [19:13] are 0

## Timing
- Reset takes priority over every other input. On reset: PC=AR=IR=AC=0, Z=1, state=IDLE, control_out=0, read_en=0, write_en=0. Reset can be applied mid-instruction; any pending DRAM write is suppressed.
- Instruction latency in clocks: NOP 3; INAC, JUMP and JMPZ 4; LDAC, ADD, SUB and STAC 5.
- Deasserting start, or asserting start_2, during an instruction lets that instruction complete; the FSM enters IDLE at the next FETCH1. Registers hold their values.
- PC wraps from 511 to 0 on the 9-bit address.
- An external IRAM write while running is ignored unless start_2=1.
- control_out, read_en and write_en are combinational decodes of the current state.

## Configuration
- `TOP_CONTROL_DEBUG_EN`:
  - Defined: control_out, state, data_in_pc, alu_in_1, alu_in_2 and alu_out carry live values.
  - Undefined: these six outputs are tied to 0. Processor behaviour is otherwise identical.

## Test plan
- Reset with reset_n=0 for 2 clocks -> pc_out=0, ar_out=0, state=0, write_en=0, read_en=0.
- start_2=1, write IRAM[1..5] = 0x0000, 0x0401, 0x0802, 0x1400, 0x0C03 -> iram_in shows each word when AR addresses it.
- start_2=0, start=1, run the program above -> AC is 1, then 3, then 4; DRAM[3]=4 with write_en high for exactly one clock in STAC2.
- LDAC of DRAM[0] -> Z=1; JMPZ 10 -> pc_out=10.
- Program IRAM[1]=0xFC00 (HALT) and run -> state=63 held, pc_out=2. Then start=0 -> state=0.
- Pulse iram_write_ext with start_2=0 -> IRAM is unchanged.
